// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single data-memory port: CPU (master 0) and debug/loader (master 1).
// Each access is a registered grant (ACC) followed by a response (RSP) cycle.
module dmem_arbiter #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 32,
  parameter int CPU_PRIO   = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [3:0]        m0_amp,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              cpu_stall,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [3:0]        m1_amp,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_we,
  output logic [3:0]        ram_amp,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wd,
  input  logic [DATA_W-1:0] ram_rd
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RSP  = 2'd2
  } state_t;

  localparam logic       PRIO_EN    = (CPU_PRIO != 0);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t              state_r, state_s;
  logic                sel_r;          // 0 = master 0 owns the current access
  logic                last_winner_r;
  logic [3:0]          starve_r, starve_s;
  logic                win_s;
  logic                any_req_s;
  logic                arb_go_s;
  logic                cmd_we_r;
  logic [3:0]          cmd_amp_r;
  logic [ADDR_W-1:0]   cmd_addr_r;
  logic [DATA_W-1:0]   cmd_wdata_r;
  logic [DATA_W-1:0]   m0_rdata_r, m1_rdata_r;

  assign any_req_s = m0_req | m1_req;
  assign arb_go_s  = any_req_s & ((state_r == IDLE) | (state_r == RSP));

  // Arbitration: winner select and starvation counter update.
  always_comb begin
    win_s    = last_winner_r;
    starve_s = starve_r;
    if (m0_req && m1_req) begin
      if (!PRIO_EN) begin
        win_s    = ~last_winner_r;
        starve_s = 4'd0;
      end else if (starve_r >= STARVE_LIM) begin
        win_s    = 1'b1;
        starve_s = 4'd0;
      end else begin
        win_s    = 1'b0;
        starve_s = starve_r + 4'd1;
      end
    end else if (m1_req) begin
      win_s    = 1'b1;
      starve_s = 4'd0;
    end else if (m0_req) begin
      win_s    = 1'b0;
      starve_s = 4'd0;
    end else begin
      win_s    = last_winner_r;
      starve_s = starve_r;
    end
  end

  // Next-state logic; RSP chains straight into ACC when a request is waiting.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = any_req_s ? ACC : IDLE;
      ACC:     state_s = RSP;
      RSP:     state_s = any_req_s ? ACC : IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Command register and arbitration history, loaded on every arbitration.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel_r         <= 1'b0;
      last_winner_r <= 1'b1;
      starve_r      <= 4'd0;
      cmd_we_r      <= 1'b0;
      cmd_amp_r     <= 4'd0;
      cmd_addr_r    <= '0;
      cmd_wdata_r   <= '0;
    end else if (arb_go_s) begin
      sel_r         <= win_s;
      last_winner_r <= win_s;
      starve_r      <= starve_s;
      cmd_we_r      <= win_s ? m1_we    : m0_we;
      cmd_amp_r     <= win_s ? m1_amp   : m0_amp;
      cmd_addr_r    <= win_s ? m1_addr  : m0_addr;
      cmd_wdata_r   <= win_s ? m1_wdata : m0_wdata;
    end else begin
      sel_r         <= sel_r;
      last_winner_r <= last_winner_r;
      starve_r      <= starve_r;
      cmd_we_r      <= cmd_we_r;
      cmd_amp_r     <= cmd_amp_r;
      cmd_addr_r    <= cmd_addr_r;
      cmd_wdata_r   <= cmd_wdata_r;
    end
  end

  // Read-data capture at the end of ACC into the owning master's register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m0_rdata_r <= '0;
      m1_rdata_r <= '0;
    end else if (state_r == ACC) begin
      if (sel_r) begin
        m1_rdata_r <= ram_rd;
      end else begin
        m0_rdata_r <= ram_rd;
      end
    end else begin
      m0_rdata_r <= m0_rdata_r;
      m1_rdata_r <= m1_rdata_r;
    end
  end

  // Handshakes decode straight from registered state so reset clears them at once.
  assign m0_gnt    = (state_r == ACC) & ~sel_r;
  assign m1_gnt    = (state_r == ACC) &  sel_r;
  assign m0_rvalid = (state_r == RSP) & ~sel_r;
  assign m1_rvalid = (state_r == RSP) &  sel_r;
  assign m0_rdata  = m0_rdata_r;
  assign m1_rdata  = m1_rdata_r;
  assign cpu_stall = m0_req & ~m0_rvalid;

  assign ram_we   = cmd_we_r & (state_r == ACC);
  assign ram_amp  = cmd_amp_r;
  assign ram_addr = cmd_addr_r;
  assign ram_wd   = cmd_wdata_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one priority instance with a memory model, one round-robin instance.
module tb_dmem_arbiter;

  localparam int AW = 7;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rstn;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [3:0]    m0_amp, m1_amp;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, cpu_stall, ram_we;
  logic [DW-1:0] m0_rdata, m1_rdata, ram_wd, ram_rd;
  logic [3:0]    ram_amp;
  logic [AW-1:0] ram_addr;

  logic          rr_m0_req, rr_m1_req;
  logic          rr_m0_gnt, rr_m0_rvalid, rr_m1_gnt, rr_m1_rvalid, rr_cpu_stall, rr_ram_we;
  logic [DW-1:0] rr_m0_rdata, rr_m1_rdata, rr_ram_wd, rr_ram_rd;
  logic [3:0]    rr_ram_amp;
  logic [AW-1:0] rr_ram_addr;

  logic [DW-1:0] mem [0:127];
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;

  typedef struct {
    logic          mst;
    logic          chk_rd;
    logic [DW-1:0] rd;
  } exp_t;

  exp_t sbq[$];
  logic rrq[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CPU_PRIO(1), .STARVE_MAX(4)) dut (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_amp(m0_amp), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .cpu_stall(cpu_stall),
    .m1_req(m1_req), .m1_we(m1_we), .m1_amp(m1_amp), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_we(ram_we), .ram_amp(ram_amp), .ram_addr(ram_addr), .ram_wd(ram_wd), .ram_rd(ram_rd)
  );

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CPU_PRIO(0), .STARVE_MAX(4)) dut_rr (
    .clk(clk), .rstn(rstn),
    .m0_req(rr_m0_req), .m0_we(m0_we), .m0_amp(m0_amp), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(rr_m0_gnt), .m0_rvalid(rr_m0_rvalid), .m0_rdata(rr_m0_rdata), .cpu_stall(rr_cpu_stall),
    .m1_req(rr_m1_req), .m1_we(m1_we), .m1_amp(m1_amp), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(rr_m1_gnt), .m1_rvalid(rr_m1_rvalid), .m1_rdata(rr_m1_rdata),
    .ram_we(rr_ram_we), .ram_amp(rr_ram_amp), .ram_addr(rr_ram_addr), .ram_wd(rr_ram_wd),
    .ram_rd(rr_ram_rd)
  );

  // Data memory model: combinational read, clocked write, plus a bench-side preload port.
  assign ram_rd    = mem[ram_addr];
  assign rr_ram_rd = {25'd0, rr_ram_addr};

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (ram_we) mem[ram_addr] <= ram_wd;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_addr = a;
    ld_data = d;
    ld_en   = 1'b1;
    tick();
    ld_en   = 1'b0;
  endtask

  // ACC cycle: the head of the scoreboard must own the grant.
  task automatic sb_acc(input string tag);
    chk({tag, " sb_nonempty"}, 64'(sbq.size() != 0), 64'd1);
    if (sbq.size() != 0) begin
      chk({tag, " m0_gnt"}, 64'(m0_gnt), 64'(!sbq[0].mst));
      chk({tag, " m1_gnt"}, 64'(m1_gnt), 64'(sbq[0].mst));
    end
  endtask

  // RSP cycle: pop the head, check rvalid and (for reads) the returned data.
  task automatic sb_rsp(input string tag);
    exp_t e;
    chk({tag, " sb_nonempty"}, 64'(sbq.size() != 0), 64'd1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk({tag, " m0_rvalid"}, 64'(m0_rvalid), 64'(!e.mst));
      chk({tag, " m1_rvalid"}, 64'(m1_rvalid), 64'(e.mst));
      chk({tag, " ram_we_rsp"}, 64'(ram_we), 64'd0);
      if (e.chk_rd) chk({tag, " rdata"}, 64'(e.mst ? m1_rdata : m0_rdata), 64'(e.rd));
    end
  endtask

  task automatic single(input string tag, input logic mst, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd);
    exp_t e;
    if (mst) begin
      m1_req = 1'b1; m1_we = we; m1_amp = 4'hF; m1_addr = a; m1_wdata = wd;
    end else begin
      m0_req = 1'b1; m0_we = we; m0_amp = 4'hF; m0_addr = a; m0_wdata = wd;
    end
    e.mst = mst; e.chk_rd = !we; e.rd = exp_rd;
    sbq.push_back(e);
    tick();
    sb_acc(tag);
    m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
    tick();
    sb_rsp(tag);
    tick();
    chk({tag, " idle_gnt"}, 64'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}), 64'd0);
  endtask

  initial begin
    exp_t e;
    logic exp_m;
    rstn = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    m0_req = 1'b0; m0_we = 1'b0; m0_amp = 4'd0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_amp = 4'd0; m1_addr = '0; m1_wdata = '0;
    rr_m0_req = 1'b0; rr_m1_req = 1'b0;
    #12;
    chk("rst handshakes", 64'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, cpu_stall}), 64'd0);
    chk("rst ram_we", 64'(ram_we), 64'd0);
    chk("rst ram_cmd", {ram_amp, ram_addr, ram_wd}, 64'd0);
    chk("rst rdata", {m0_rdata, m1_rdata}, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // Round-robin instance, both requesting from reset: m0 first, then alternate.
    for (int i = 0; i < 6; i++) rrq.push_back(i[0]);
    rr_m0_req = 1'b1; rr_m1_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_m = rrq.pop_front();
      chk("rr m0_gnt", 64'(rr_m0_gnt), 64'(!exp_m));
      chk("rr m1_gnt", 64'(rr_m1_gnt), 64'(exp_m));
      chk("rr ram_we", 64'(rr_ram_we), 64'd0);
      tick();
      chk("rr rvalid", 64'({rr_m0_rvalid, rr_m1_rvalid}), exp_m ? 64'd1 : 64'd2);
      chk("rr rdata", exp_m ? 64'(rr_m1_rdata) : 64'(rr_m0_rdata), 64'd0);
    end
    rr_m0_req = 1'b0; rr_m1_req = 1'b0;
    tick();
    chk("rr idle", 64'({rr_m0_gnt, rr_m1_gnt, rr_cpu_stall}), 64'd0);

    // m0 read with stall observation.
    preload(7'h05, 32'hDEADBEEF);
    m0_req = 1'b1; m0_we = 1'b0; m0_amp = 4'hF; m0_addr = 7'h05;
    e.mst = 1'b0; e.chk_rd = 1'b1; e.rd = 32'hDEADBEEF;
    sbq.push_back(e);
    #1;
    chk("t1 stall_req", 64'(cpu_stall), 64'd1);
    chk("t1 no_early_gnt", 64'(m0_gnt), 64'd0);
    tick();
    sb_acc("t1");
    chk("t1 stall_acc", 64'(cpu_stall), 64'd1);
    chk("t1 ram_addr", 64'(ram_addr), 64'h05);
    chk("t1 ram_we", 64'(ram_we), 64'd0);
    m0_req = 1'b0;
    tick();
    sb_rsp("t1");
    chk("t1 stall_rsp", 64'(cpu_stall), 64'd0);
    tick();
    chk("t1 rvalid_off", 64'(m0_rvalid), 64'd0);
    chk("t1 rdata_hold", 64'(m0_rdata), 64'hDEADBEEF);

    // m1 word write.
    m1_req = 1'b1; m1_we = 1'b1; m1_amp = 4'hF; m1_addr = 7'h10; m1_wdata = 32'h12345678;
    e.mst = 1'b1; e.chk_rd = 1'b0; e.rd = '0;
    sbq.push_back(e);
    tick();
    sb_acc("t2");
    chk("t2 ram_we", 64'(ram_we), 64'd1);
    chk("t2 ram_addr", 64'(ram_addr), 64'h10);
    chk("t2 ram_wd", 64'(ram_wd), 64'h12345678);
    chk("t2 ram_amp", 64'(ram_amp), 64'hF);
    m1_req = 1'b0; m1_we = 1'b0;
    tick();
    sb_rsp("t2");
    tick();
    chk("t2 idle", 64'({ram_we, m1_rvalid, m1_gnt}), 64'd0);
    single("t2 readback", 1'b0, 1'b0, 7'h10, 32'd0, 32'h12345678);

    // Fixed priority with starvation cap: m0 x4 then m1, back to back.
    preload(7'h01, 32'h1111_0001);
    preload(7'h02, 32'h2222_0002);
    for (int i = 0; i < 10; i++) begin
      e.mst = ((i % 5) == 4); e.chk_rd = 1'b1; e.rd = e.mst ? 32'h2222_0002 : 32'h1111_0001;
      sbq.push_back(e);
    end
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 7'h01;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 7'h02;
    for (int i = 0; i < 10; i++) begin
      tick();
      sb_acc("t3");
      tick();
      sb_rsp("t3");
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
    chk("t3 idle", 64'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}), 64'd0);

    // Reset in the middle of an ACC write.
    preload(7'h20, 32'h11111111);
    m0_req = 1'b1; m0_we = 1'b1; m0_amp = 4'hF; m0_addr = 7'h20; m0_wdata = 32'hCAFEF00D;
    tick();
    chk("t5 acc_we", 64'(ram_we), 64'd1);
    chk("t5 acc_gnt", 64'(m0_gnt), 64'd1);
    m0_req = 1'b0; m0_we = 1'b0;
    #1 rstn = 1'b0;
    #1;
    chk("t5 rst_we", 64'(ram_we), 64'd0);
    chk("t5 rst_hs", 64'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}), 64'd0);
    chk("t5 rst_cmd", {ram_amp, ram_addr, ram_wd}, 64'd0);
    chk("t5 rst_rdata", 64'(m0_rdata), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    chk("t5 no_rvalid", 64'({m0_rvalid, m0_gnt, ram_we}), 64'd0);
    tick();
    chk("t5 still_idle", 64'({m0_rvalid, m0_gnt, ram_we}), 64'd0);
    single("t5 aborted_write", 1'b0, 1'b0, 7'h20, 32'd0, 32'h11111111);

    // Per-master read-data registers are independent.
    preload(7'h30, 32'hAAAA0000);
    preload(7'h31, 32'h5555FFFF);
    single("t6 m0", 1'b0, 1'b0, 7'h30, 32'd0, 32'hAAAA0000);
    single("t6 m1", 1'b1, 1'b0, 7'h31, 32'd0, 32'h5555FFFF);
    chk("t6 m0_hold", 64'(m0_rdata), 64'hAAAA0000);
    chk("t6 m1_rdata", 64'(m1_rdata), 64'h5555FFFF);
    chk("t6 sb_drained", 64'(sbq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-master arbiter that shares the single data-memory port between the CPU data path (master 0) and a debug/loader port (master 1), e.g. a UART program loader or a bench-side memory inspector.
- Sits between the memory-mapped I/O bus's RAM-side signals and the data memory.
- Sequences each access as a registered grant, access and response.
- Selects between the masters by fixed priority with a starvation cap, or by round-robin.

Parameters:
ADDR_W, 7, word address width of the data memory
DATA_W, 32, data width
CPU_PRIO, 1, 1 = master 0 wins ties (starvation-capped); 0 = pure round-robin
STARVE_MAX, 4, max consecutive tied arbitrations master 1 may lose when CPU_PRIO=1 (range 1..15)

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  reset, asynchronous, active-low
m0_req  in  1  CPU access request; held with command until m0_gnt
m0_we  in  1  CPU write enable
m0_amp  in  4  CPU access pattern (1111 word, 0011 half, 0001 byte)
m0_addr  in  ADDR_W  CPU word address
m0_wdata  in  DATA_W  CPU write data
m0_gnt  out  1  one-cycle pulse: CPU command accepted
m0_rvalid  out  1  one-cycle pulse: CPU read data valid / write done
m0_rdata  out  DATA_W  CPU read data
cpu_stall  out  1  m0_req & ~m0_rvalid (combinational), to freeze the pipeline
m1_req, m1_we, m1_amp, m1_addr, m1_wdata  in  1/1/4/ADDR_W/DATA_W  master-1 command, same rules as m0
m1_gnt, m1_rvalid  out  1  as m0
m1_rdata  out  DATA_W  as m0
ram_we  out  1  data memory write enable
ram_amp  out  4  data memory access pattern
ram_addr  out  ADDR_W  data memory address
ram_wd  out  DATA_W  data memory write data
ram_rd  in  DATA_W  data memory read data, combinational from ram_addr

Behaviour:
- Clock and reset: one clock, clk. rstn is asynchronous and active-low.
- Reset values (effective immediately on rstn low):
  - state = IDLE.
  - All gnt and rvalid outputs = 0.
  - ram_we = 0.
  - ram_amp/addr/wd = 0 (command register cleared).
  - m0_rdata = m1_rdata = 0.
  - last_winner = 1, so master 0 wins the first tie.
  - starve_cnt = 0.
- FSM states: IDLE, ACC, RSP.
- IDLE:
  - At a clock edge with any req high: arbitrate.
  - Latch the winner's we/amp/addr/wdata into the command register and record sel.
  - Go to ACC.
  - With no req high: stay in IDLE.
- ACC (exactly 1 cycle):
  - ram_addr/amp/wd come from the command register.
  - ram_we = cmd_we (high only in ACC).
  - gnt of sel is high this cycle only.
  - At the edge: capture ram_rd into sel's rdata register (writes also capture; the value is don't-care).
  - Go to RSP.
- RSP (exactly 1 cycle):
  - rvalid of sel is high.
  - ram_we = 0; ram_addr/amp/wd hold.
  - At the edge: if any req is high, arbitrate and go to ACC (back-to-back). Otherwise go to IDLE.
  - A requester that saw gnt must drop req or present its next command by the end of ACC. A req still high during RSP is a new request.
- Latency:
  - req first sampled at edge k gives gnt in cycle k+1 and rvalid in cycle k+2.
  - Sustained throughput is one access per 2 cycles.
- rdata registers hold their value until the next access by the same master.
- Arbitration with a single requester: that master wins.
- Arbitration with both requesting:
  - CPU_PRIO=0: the master that is not last_winner wins.
  - CPU_PRIO=1: master 0 wins and starve_cnt increments, unless starve_cnt == STARVE_MAX. In that case master 1 wins and starve_cnt clears.
  - starve_cnt also clears whenever master 1 wins or master 1 is not requesting. It saturates and never wraps.
  - last_winner updates on every arbitration.
- m*_amp passes through unchanged; no alignment checking is done.
- m*_wdata is DATA_W wide, with no truncation or extension.
- Reset mid-access: an ACC write is aborted (ram_we drops asynchronously) and no rvalid is issued. Requesters must reissue after reset.
- cpu_stall is 0 during reset, because m0_rvalid is 0 and m0_req is expected to be 0.

Test Plan:
- Reset, then m0 read of addr 0x05 with ram_rd = 0xDEADBEEF → m0_gnt in the cycle after the req edge, m0_rvalid the next cycle, m0_rdata = 0xDEADBEEF, cpu_stall high for 2 cycles.
- m1 write to addr 0x10, data 0x12345678, amp 1111 → ram_we high for exactly 1 cycle with ram_addr = 0x10 and ram_wd = 0x12345678; m1_rvalid the following cycle.
- CPU_PRIO=1, STARVE_MAX=4, both masters request continuously → grant sequence m0,m0,m0,m0,m1,m0,m0,m0,m0,m1,…; accesses back-to-back every 2 cycles, never returning to IDLE.
- CPU_PRIO=0, both masters request continuously from reset → grants alternate m0,m1,m0,m1.
- rstn low in the middle of an ACC write → ram_we=0 and all gnt/rvalid=0 immediately; state IDLE after release; no rvalid for the aborted write.
- m0 reads 0xAAAA0000, then m1 reads 0x5555FFFF → m0_rdata remains 0xAAAA0000 while m1_rdata = 0x5555FFFF.
